// File: rtl/ws2812b_frame_seq.sv
// Frame sequencer for a WS2812B chain: buffers LED_NUM colours and hands them one
// pixel at a time to the bit driver, then holds the latch gap. Optional macro: WS2812B_BRIGHTNESS_EN.
module ws2812b_frame_seq #(
  parameter int LED_NUM   = 8,
  parameter int ADDR_W    = 3,
  parameter int RESET_CNT = 1620
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
`ifdef WS2812B_BRIGHTNESS_EN
  input  logic [7:0]        bright,
`endif
  output logic              frame_busy,
  output logic              frame_done,
  output logic              drv_en,
  output logic [7:0]        drv_red,
  output logic [7:0]        drv_green,
  output logic [7:0]        drv_blue,
  input  logic              drv_busy
);

  localparam int CNT_W = (RESET_CNT > 1) ? $clog2(RESET_CNT) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LED_NUM - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(RESET_CNT - 1);

  // Driver handshake: drv_en is a one-cycle request issued only while drv_busy is low;
  // the driver acknowledges by raising drv_busy and signals completion by dropping it.
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_LATCH, S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  cnt;
  logic [23:0]       pix_mem [LED_NUM];
  logic [23:0]       load_pix;
  logic [7:0]        load_red;
  logic [7:0]        load_green;
  logic [7:0]        load_blue;

  // Out-of-range addresses match no entry and are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LED_NUM; i++) pix_mem[i] <= 24'h0;
    end else if (wr_en) begin
      for (int i = 0; i < LED_NUM; i++) begin
        if (wr_addr == ADDR_W'(i)) pix_mem[i] <= wr_data;
      end
    end
  end

  assign load_pix = pix_mem[idx];

`ifdef WS2812B_BRIGHTNESS_EN
  // (c * (bright + 1)) >> 8 so that bright=255 is an exact pass-through.
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'h00, c} * ({8'h00, b} + 16'd1);
    return prod[15:8];
  endfunction

  assign load_red   = scale(load_pix[23:16], bright);
  assign load_green = scale(load_pix[15:8], bright);
  assign load_blue  = scale(load_pix[7:0], bright);
`else
  assign load_red   = load_pix[23:16];
  assign load_green = load_pix[15:8];
  assign load_blue  = load_pix[7:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      drv_en     <= 1'b0;
      drv_red    <= 8'h0;
      drv_green  <= 8'h0;
      drv_blue   <= 8'h0;
    end else begin
      drv_en     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            frame_busy <= 1'b1;
            idx        <= '0;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          drv_red   <= load_red;
          drv_green <= load_green;
          drv_blue  <= load_blue;
          state     <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!drv_busy) begin
            drv_en <= 1'b1;
            state  <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (drv_busy) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!drv_busy) begin
            if (idx == LAST_IDX) begin
              cnt   <= '0;
              state <= S_LATCH;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_LOAD;
            end
          end
        end
        S_LATCH: begin
          if (cnt == LAST_CNT) begin
            frame_done <= 1'b1;
            frame_busy <= 1'b0;
            state      <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ws2812b_frame_seq.md
Name: ws2812b_frame_seq

Overview:
- Frame sequencer sitting directly upstream of the single-pixel WS2812B bit driver.
- Holds colours for a chain of LED_NUM pixels in an internal register file and feeds them to the driver one pixel at a time, handshaking on drv_en/drv_busy.
- After the last pixel it holds the line idle for the latch (reset) gap, then pulses frame_done.

Parameters:
- LED_NUM, 8, number of pixels in the chain (1..2^ADDR_W).
- ADDR_W, 3, pixel address width.
- RESET_CNT, 1620, latch gap length in clk cycles (60 us at 27 MHz).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  request one frame transmission; sampled only in IDLE.
- wr_en  input  1  pixel buffer write strobe.
- wr_addr  input  ADDR_W  pixel index to write.
- wr_data  input  24  colour {R[23:16], G[15:8], B[7:0]}.
- frame_busy  output  1  high from frame acceptance to frame_done.
- frame_done  output  1  one-cycle pulse at end of latch gap.
- drv_en  output  1  one-cycle request to the bit driver.
- drv_red  output  8  red byte presented to the driver.
- drv_green  output  8  green byte presented to the driver.
- drv_blue  output  8  blue byte presented to the driver.
- drv_busy  input  1  bit-driver busy flag.

Behaviour:
- Reset (async, rst low):
  - All outputs 0; state IDLE; pixel index 0; latch counter 0.
  - All LED_NUM buffer entries cleared to 24'h0.
  - Reset mid-frame abandons the frame with no frame_done. The driver shares rst.
- Buffer writes:
  - Accepted on any cycle wr_en=1, in any state.
  - wr_addr >= LED_NUM is ignored.
  - A pixel's value is sampled in LOAD, so a write to a pixel already loaded affects the next frame only.
- States: IDLE, LOAD, ISSUE, WAIT_ACK, WAIT_DONE, LATCH, DONE.
  - IDLE: if start, set frame_busy=1 and idx=0, go to LOAD. Otherwise remain.
  - LOAD: register buffer[idx] onto drv_red/green/blue, go to ISSUE. Colour outputs hold until the next LOAD.
  - ISSUE: if drv_busy=0, assert drv_en for exactly one cycle and go to WAIT_ACK. If drv_busy=1, wait without asserting drv_en.
  - WAIT_ACK: wait for drv_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for drv_busy=0. Then if idx==LED_NUM-1, clear the counter and go to LATCH; else idx+1 and go to LOAD.
  - LATCH: count RESET_CNT cycles (counter 0..RESET_CNT-1), then go to DONE.
  - DONE: frame_done=1 for one cycle; frame_busy=0 at the same edge; go to IDLE.
- Latency:
  - start sampled at edge N → frame_busy=1 after edge N.
  - drv_en=1 during the cycle after edge N+2 (IDLE→LOAD→ISSUE).
- start is ignored whenever state != IDLE, including the DONE cycle. No queuing.
- drv_en is never high on two consecutive cycles and never while drv_busy=1.
- LED_NUM=1: a single LOAD/ISSUE/WAIT pass, then LATCH.
- idx width is ADDR_W. idx never exceeds LED_NUM-1, so there is no wrap-around.

Optional Feature:
- WS2812B_BRIGHTNESS_EN defined:
  - Adds input port `bright [7:0]`.
  - In LOAD each channel becomes (c*(bright+1))>>8, using a 16-bit product and taking bits [15:8].
  - bright=255 passes colours unchanged; bright=0 yields 0 for all c.
  - bright is sampled in LOAD per pixel. Latency is unchanged.
- Undefined: no bright port; colours pass unmodified.

Test Plan:
- Bench setup: LED_NUM=3, RESET_CNT=10, driver BFM raises busy 1 cycle after drv_en and holds it 24 cycles.
- Write pix0=FF0000, pix1=00FF00, pix2=0000FF, pulse start → exactly 3 drv_en pulses with (R,G,B) = (FF,00,00), (00,FF,00), (00,00,FF) in order. frame_done pulses 10 cycles after the last busy falls. frame_busy is high throughout.
- Pulse start again mid-frame and during DONE → ignored; exactly 3 drv_en pulses and one frame_done.
- Hold drv_busy=1 from the BFM before the first ISSUE for 5 cycles → drv_en delayed until busy low; no drv_en while busy.
- During the frame, write pix0=123456 after pix0 is loaded and pix2=ABCDEF before pix2 is loaded → current frame sends the old pix0 and ABCDEF for pix2. Next frame sends 12,34,56 for pix0. Write to wr_addr=5 is ignored.
- Assert rst low while in WAIT_DONE on pix1 → all outputs 0 immediately, no frame_done. After release, a start sends all pixels as 000000 (buffer cleared).
- With WS2812B_BRIGHTNESS_EN, bright=127, pix=FF8001 → driver receives (7F, 40, 00). With bright=255 the driver receives (FF, 80, 01).
